// File: rtl/frac_div_ctrl.sv
// Fractional divider sequencer: drives an external ripple adder as a phase accumulator.
// Optional macro FRAC_ACC_CLR_EN: applying a pending config also clears the accumulator.
module frac_div_ctrl #(
  parameter int WIDTH = 8,
  parameter int NW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [NW-1:0]    cfg_n,
  input  logic [WIDTH-1:0] cfg_k,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_pulse,
  output logic             div_sel
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_kAct;
  logic [WIDTH-1:0] r_kPend;
  logic [NW-1:0]    r_nAct;
  logic [NW-1:0]    r_nPend;
  logic [NW-1:0]    r_cnt;
  logic             r_pend;
  logic             r_outPulse;
  logic             r_divSel;

  logic             w_xfer;
  logic [NW-1:0]    w_nClamp;
  logic [NW-1:0]    w_nNext;
  logic [NW-1:0]    w_nIdle;
  logic [NW-1:0]    w_cntReload;
  logic [WIDTH-1:0] w_accBoundary;

  assign cfg_ready = ~r_pend;
  assign add_a     = r_acc;
  assign add_b     = r_kAct;
  assign out_pulse = r_outPulse;
  assign div_sel   = r_divSel;

  assign w_xfer      = cfg_valid & ~r_pend;
  assign w_nClamp    = (cfg_n < NW'(2)) ? NW'(2) : cfg_n;
  assign w_nNext     = r_pend ? r_nPend : r_nAct;
  assign w_nIdle     = r_pend ? r_nPend : (w_xfer ? w_nClamp : r_nAct);
  // A carry out of the accumulator stretches the next period by one clock.
  assign w_cntReload = w_nNext - NW'(1) + {{(NW-1){1'b0}}, add_cout};

`ifdef FRAC_ACC_CLR_EN
  assign w_accBoundary = r_pend ? '0 : add_s;
`else
  assign w_accBoundary = add_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_kAct     <= '0;
      r_kPend    <= '0;
      r_nAct     <= NW'(2);
      r_nPend    <= NW'(2);
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_outPulse <= 1'b0;
      r_divSel   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_outPulse <= 1'b0;
          r_acc      <= '0;
          r_divSel   <= 1'b0;
          // A config parked while en was dropping is applied before restarting.
          if (r_pend) begin
            r_nAct <= r_nPend;
            r_kAct <= r_kPend;
            r_pend <= 1'b0;
          end else if (w_xfer) begin
            r_nAct <= w_nClamp;
            r_kAct <= cfg_k;
          end
          if (en) begin
            r_state <= RUN;
            r_cnt   <= w_nIdle - NW'(1);
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_nPend <= w_nClamp;
            r_kPend <= cfg_k;
            r_pend  <= 1'b1;
          end else if (en && r_cnt == '0 && r_pend) begin
            r_nAct <= r_nPend;
            r_kAct <= r_kPend;
            r_pend <= 1'b0;
          end
          if (!en) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_divSel   <= 1'b0;
            r_outPulse <= 1'b0;
          end else if (r_cnt == '0) begin
            r_outPulse <= 1'b1;
            r_acc      <= w_accBoundary;
            r_divSel   <= add_cout;
            r_cnt      <= w_cntReload;
          end else begin
            r_outPulse <= 1'b0;
            r_cnt      <= r_cnt - NW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Self-checking bench for frac_div_ctrl: table of (N,K) rows plus handshake, en-drop and reset sequences.
module tb_frac_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_n;
  logic [7:0] cfg_k;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_s;
  logic       add_cout;
  logic       out_pulse;
  logic       div_sel;

  int checks;
  int fails;

  typedef struct {
    logic [7:0] n;
    logic [7:0] k;
    int         expSum;
  } vec_t;

  vec_t vecs[$];

  frac_div_ctrl #(.WIDTH(8), .NW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_n     (cfg_n),
    .cfg_k     (cfg_k),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_pulse (out_pulse),
    .div_sel   (div_sel)
  );

  // External 8-bit adder the sequencer is meant to drive.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [7:0] n, input logic [7:0] k);
    en        = e;
    cfg_valid = v;
    cfg_n     = n;
    cfg_k     = k;
  endtask

  task automatic waitPulse(input int limit, output int cycles);
    bit seen;
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (out_pulse) seen = 1;
    end
    if (!seen) begin
      checkOutput("pulseTimeout", cycles, -1);
    end
  endtask

  task automatic configIdle(input logic [7:0] n, input logic [7:0] k);
    @(negedge clk);
    applyStimulus(0, 0, n, k);
    repeat (3) @(negedge clk);
    checkOutput("cfgReadyIdle", int'(cfg_ready), 1);
    applyStimulus(0, 1, n, k);
    @(negedge clk);
    applyStimulus(0, 0, n, k);
    checkOutput("kLoadedIdle", int'(add_b), int'(k));
  endtask

  initial begin
    int cyc;
    int effN;
    int acc;
    int carry;
    int prevCarry;
    int sum;
    int elapsed;
    int pulses;
    logic [7:0] rn;
    logic [7:0] rk;

    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    applyStimulus(0, 0, 8'd0, 8'd0);

    vecs.push_back('{n: 8'd4,   k: 8'd0,   expSum: 16});
    vecs.push_back('{n: 8'd4,   k: 8'd128, expSum: 18});
    vecs.push_back('{n: 8'd4,   k: 8'd64,  expSum: 17});
    vecs.push_back('{n: 8'd0,   k: 8'd0,   expSum: 8});
    vecs.push_back('{n: 8'd1,   k: 8'd128, expSum: 10});
    vecs.push_back('{n: 8'd255, k: 8'd255, expSum: 1023});
    for (int r = 0; r < 4; r++) begin
      rn = 8'($urandom_range(2, 20));
      rk = 8'($urandom_range(0, 255));
      // Four periods after the first: 4*N plus the number of accumulator wraps.
      vecs.push_back('{n: rn, k: rk, expSum: 4 * int'(rn) + (4 * int'(rk)) / 256});
    end

    repeat (3) @(negedge clk);
    checkOutput("rstOutPulse", int'(out_pulse), 0);
    checkOutput("rstDivSel", int'(div_sel), 0);
    checkOutput("rstCfgReady", int'(cfg_ready), 1);
    checkOutput("rstAddA", int'(add_a), 0);
    checkOutput("rstAddB", int'(add_b), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      configIdle(vecs[i].n, vecs[i].k);
      effN = (vecs[i].n < 2) ? 2 : int'(vecs[i].n);
      acc = 0;
      prevCarry = 0;
      sum = 0;
      applyStimulus(1, 0, vecs[i].n, vecs[i].k);
      @(negedge clk);
      checkOutput("firstDivSel", int'(div_sel), 0);
      waitPulse(600, cyc);
      checkOutput("firstLatency", cyc + 1, effN + 1);
      for (int p = 1; p <= 5; p++) begin
        if (p > 1) begin
          waitPulse(600, cyc);
          checkOutput("period", cyc, effN + prevCarry);
          sum += cyc;
        end
        carry = (acc + int'(vecs[i].k)) / 256;
        acc   = (acc + int'(vecs[i].k)) % 256;
        checkOutput("divSel", int'(div_sel), carry);
        checkOutput("accAfterBoundary", int'(add_a), acc);
        prevCarry = carry;
      end
      checkOutput("sumOf4Periods", sum, vecs[i].expSum);
    end

    // Mid-period config change: current period keeps N=4, the next one uses N=6.
    configIdle(8'd4, 8'd0);
    applyStimulus(1, 0, 8'd4, 8'd0);
    waitPulse(100, cyc);
    @(negedge clk);
    applyStimulus(1, 1, 8'd6, 8'd0);
    @(negedge clk);
    applyStimulus(1, 0, 8'd6, 8'd0);
    checkOutput("cfgReadyBusy", int'(cfg_ready), 0);
    waitPulse(100, cyc);
    elapsed = 2 + cyc;
    checkOutput("periodBeforeSwitch", elapsed, 4);
    checkOutput("cfgReadyReturn", int'(cfg_ready), 1);
    waitPulse(100, cyc);
    checkOutput("periodAfterSwitch", cyc, 6);

    // Dropping en mid-period: no more pulses and the accumulator clears.
    @(negedge clk);
    applyStimulus(1, 1, 8'd5, 8'd100);
    @(negedge clk);
    applyStimulus(1, 0, 8'd5, 8'd100);
    waitPulse(100, cyc);
    waitPulse(100, cyc);
    checkOutput("accNonZeroBeforeDrop", int'(add_a != 8'd0), 1);
    @(negedge clk);
    applyStimulus(0, 0, 8'd5, 8'd100);
    @(negedge clk);
    checkOutput("dropAddA", int'(add_a), 0);
    checkOutput("dropDivSel", int'(div_sel), 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_pulse) pulses++;
    end
    checkOutput("dropNoPulses", pulses, 0);

    // Asynchronous reset while a pulse is showing, with no clock edge in between.
    applyStimulus(1, 0, 8'd5, 8'd100);
    waitPulse(100, cyc);
    checkOutput("pulseBeforeReset", int'(out_pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstOutPulse", int'(out_pulse), 0);
    checkOutput("asyncRstAddA", int'(add_a), 0);
    checkOutput("asyncRstAddB", int'(add_b), 0);
    checkOutput("asyncRstDivSel", int'(div_sel), 0);
    checkOutput("asyncRstCfgReady", int'(cfg_ready), 1);
    applyStimulus(0, 0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
